time_counter: RTL and testbench
===============================

Name: time_counter

Overview:
- Time-keeping core of the digital clock. Consumes the 1 Hz square wave from the clock divider and maintains hours, minutes and seconds as packed BCD.
- Feeds the display scanner downstream.
- Runs entirely on the system clock CP; CP_1Hz is treated as a data input, synchronised and edge-detected. It is never used as a clock.
- Provides RUN / SET_HOUR / SET_MIN modes driven by two pre-debounced buttons.

Parameters:
- SYNC_STAGES, 2, flops in each input synchroniser (CP_1Hz, mode_btn, adj_btn); legal range 2..4.
- INIT_HOUR, 8'h00, packed-BCD hour loaded on reset; must be 00..23.
- INIT_MIN, 8'h00, packed-BCD minute loaded on reset; must be 00..59.

Ports:
- CP  input  1  system clock, 100 MHz.
- CR  input  1  reset; synchronous, active-high.
- CP_1Hz  input  1  1 Hz square wave from the divider; asynchronous to CP logic.
- EN  input  1  run enable; when low, RUN-mode ticks are ignored.
- mode_btn  input  1  debounced level; each rising edge advances the mode.
- adj_btn  input  1  debounced level; each rising edge increments the selected field.
- hour_bcd  output  8  hours, packed BCD, 00..23.
- min_bcd  output  8  minutes, packed BCD, 00..59.
- sec_bcd  output  8  seconds, packed BCD, 00..59.
- mode  output  2  0=RUN, 1=SET_HOUR, 2=SET_MIN.
- day_pulse  output  1  one-CP-cycle pulse on rollover 23:59:59 -> 00:00:00.

Behaviour:
- Reset (CR high at a CP edge):
  - hour_bcd=INIT_HOUR, min_bcd=INIT_MIN, sec_bcd=00, mode=RUN, day_pulse=0.
  - Synchronisers and edge-detect flops cleared.
  - A mid-operation reset overrides every other event in that cycle.
- Input conditioning:
  - Each input passes through a SYNC_STAGES synchroniser plus one history flop.
  - tick = synced CP_1Hz high and history low. mode_edge and adj_edge are formed the same way.
  - Each edge signal is high for exactly one CP cycle per input rising edge.
- Latency: an output changes on the CP edge where the edge signal is high, i.e. SYNC_STAGES+1 CP edges after the first edge that samples the input high.
- RUN with EN=1, on tick:
  - sec+1. At 59, sec wraps to 00 and min+1.
  - At min 59, min wraps to 00 and hour+1.
  - At hour 23, hour wraps to 00 and day_pulse=1 for that cycle.
- RUN with EN=0: tick is ignored and time is frozen.
- Mode FSM, advancing on mode_edge: RUN -> SET_HOUR -> SET_MIN -> RUN. Value 3 is unreachable; if decoded, the FSM returns to RUN next cycle.
- SET_HOUR / SET_MIN:
  - tick is ignored.
  - adj_edge increments the selected field only: hour 23 -> 00, minute 59 -> 00.
  - No carry into other fields and no day_pulse.
- Leaving SET_MIN for RUN clears sec_bcd to 00 in the same cycle.
- Simultaneous events:
  - mode_edge with adj_edge: mode advances, adj_edge is discarded.
  - tick with mode_edge while in RUN: the increment is applied and the mode still advances.
- BCD rules:
  - Units digit wraps 9 -> 0 with a carry into the tens digit.
  - Field limits are checked on the full packed value.
  - Non-BCD codes never appear on any output.

Optional Feature:
- Macro HOURLY_CHIME_EN.
- When defined:
  - Adds output chime (1 bit, reset 0).
  - In RUN, chime is high while min_bcd=59 and sec_bcd is in 55..59, and low otherwise.
  - chime is registered: it updates in the same cycle as sec_bcd, so it is high from the tick that sets sec_bcd=55 until the tick that sets sec_bcd=00.
  - chime is always 0 in SET modes.
- When undefined: the port and its logic are absent; no other behaviour changes.

Decomposition:
- Shared package digital_clock_pkg holds:
  - the mode enum (RUN, SET_HOUR, SET_MIN);
  - BCD limit constants (BCD_SEC_MAX=8'h59, BCD_MIN_MAX=8'h59, BCD_HOUR_MAX=8'h23);
  - the chime window start (8'h55).
- One natural sub-module, bcd_counter:
  - two-digit packed-BCD counter with parameter MAX;
  - inputs: inc, clear;
  - outputs: value, carry (combinational, high when inc and value==MAX).
  - Instantiated three times, for sec, min and hour.

Test Plan:
- Reset with INIT_HOUR=8'h23, INIT_MIN=8'h59: CR high for 2 CP cycles -> 23:59:59 reached after 59 ticks; next tick -> 00:00:00, day_pulse high for exactly 1 CP cycle.
- Latency: CP_1Hz rises -> sec_bcd changes exactly SYNC_STAGES+1 CP edges after the first sampling edge; CP_1Hz held high for 50 cycles -> only one increment.
- EN=0 for 5 ticks -> time unchanged; EN=1 -> increments resume on the next tick.
- Set flow from 10:20:33:
  - mode_edge -> SET_HOUR; 15 adj_edges -> hour 01 (wraps past 23); seconds frozen.
  - mode_edge -> SET_MIN; 40 adj_edges -> min 00, hour unchanged.
  - mode_edge -> RUN with sec=00.
- Simultaneous edges: mode_edge and adj_edge in the same cycle in SET_HOUR -> mode=SET_MIN, hour unchanged. tick and mode_edge in the same cycle in RUN -> sec+1 and mode=SET_HOUR.
- HOURLY_CHIME_EN defined, time 12:59:50 -> chime rises on the tick to :55 and falls on the tick to 13:00:00. Entering SET_HOUR while chime is high -> chime=0 the next cycle.

Source files
------------

// File: rtl/digital_clock_pkg.sv
// Shared types and constants for the digital clock time-keeping core.
// Mode encoding, packed-BCD field limits and the BCD increment helper.
package digital_clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    localparam logic [7:0] BCD_SEC_MAX  = 8'h59;
    localparam logic [7:0] BCD_MIN_MAX  = 8'h59;
    localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
    localparam logic [7:0] CHIME_START  = 8'h55;

    // Next packed-BCD value; wraps to 00 at (or past) max.
    function automatic logic [7:0] bcd_step(
        input logic [7:0] v,
        input logic [7:0] max
    );
        logic [7:0] r;
        if (v >= max)
            r = 8'h00;
        else if (v[3:0] >= 4'h9)
            r = {v[7:4] + 4'h1, 4'h0};
        else
            r = {v[7:4], v[3:0] + 4'h1};
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Two-digit packed-BCD counter wrapping at MAX, loaded with INIT on reset.
// Ports: clk, rst (sync, high), inc, clear -> value[7:0], carry (comb).
module bcd_counter
    import digital_clock_pkg::*;
#(
    parameter logic [7:0] MAX  = 8'h59,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clear,
    output logic [7:0] value,
    output logic       carry
);

    assign carry = inc && (value == MAX);

    always_ff @(posedge clk) begin
        if (rst)
            value <= INIT;
        else if (clear)
            value <= 8'h00;
        else if (inc)
            value <= bcd_step(value, MAX);
    end

endmodule

// File: rtl/time_counter.sv
// Time-keeping core: HH:MM:SS in packed BCD with RUN/SET_HOUR/SET_MIN modes.
// Ports: CP clk, CR sync reset, CP_1Hz/EN/mode_btn/adj_btn in;
// hour_bcd/min_bcd/sec_bcd/mode/day_pulse out; chime out if HOURLY_CHIME_EN.
module time_counter
    import digital_clock_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] INIT_HOUR   = 8'h00,
    parameter logic [7:0] INIT_MIN    = 8'h00
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       CP_1Hz,
    input  logic       EN,
    input  logic       mode_btn,
    input  logic       adj_btn,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] mode,
    output logic       day_pulse
`ifdef HOURLY_CHIME_EN
    ,
    output logic       chime
`endif
);

    localparam logic [1:0] ST_RUN      = MODE_RUN;
    localparam logic [1:0] ST_SET_HOUR = MODE_SET_HOUR;
    localparam logic [1:0] ST_SET_MIN  = MODE_SET_MIN;

    // CP_1Hz and the buttons are sampled as data, never as clocks.
    logic [SYNC_STAGES-1:0] s_1hz;
    logic [SYNC_STAGES-1:0] s_mode;
    logic [SYNC_STAGES-1:0] s_adj;
    logic h_1hz;
    logic h_mode;
    logic h_adj;

    always_ff @(posedge CP) begin
        if (CR) begin
            s_1hz  <= '0;
            s_mode <= '0;
            s_adj  <= '0;
            h_1hz  <= 1'b0;
            h_mode <= 1'b0;
            h_adj  <= 1'b0;
        end else begin
            s_1hz  <= {s_1hz[SYNC_STAGES-2:0], CP_1Hz};
            s_mode <= {s_mode[SYNC_STAGES-2:0], mode_btn};
            s_adj  <= {s_adj[SYNC_STAGES-2:0], adj_btn};
            h_1hz  <= s_1hz[SYNC_STAGES-1];
            h_mode <= s_mode[SYNC_STAGES-1];
            h_adj  <= s_adj[SYNC_STAGES-1];
        end
    end

    logic tick;
    logic mode_edge;
    logic adj_edge;

    assign tick      = s_1hz[SYNC_STAGES-1]  & ~h_1hz;
    assign mode_edge = s_mode[SYNC_STAGES-1] & ~h_mode;
    assign adj_edge  = s_adj[SYNC_STAGES-1]  & ~h_adj;

    logic [1:0] state;
    logic [1:0] state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:      if (mode_edge) state_nxt = ST_SET_HOUR;
            ST_SET_HOUR: if (mode_edge) state_nxt = ST_SET_MIN;
            ST_SET_MIN:  if (mode_edge) state_nxt = ST_RUN;
            default:     state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge CP) begin
        if (CR)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    assign mode = state;

    logic is_run;
    logic is_set_hour;
    logic is_set_min;
    logic adj_ok;

    assign is_run      = (state == ST_RUN);
    assign is_set_hour = (state == ST_SET_HOUR);
    assign is_set_min  = (state == ST_SET_MIN);
    // A mode press wins over an adjust press in the same cycle.
    assign adj_ok      = adj_edge & ~mode_edge;

    logic sec_inc;
    logic sec_clr;
    logic min_inc;
    logic hour_inc;
    logic sec_carry;
    logic min_carry;
    logic hour_carry;

    assign sec_inc  = is_run & tick & EN;
    assign sec_clr  = is_set_min & mode_edge;
    // Carries only ripple in RUN; SET modes touch one field alone.
    assign min_inc  = is_run ? sec_carry : (is_set_min & adj_ok);
    assign hour_inc = is_run ? min_carry : (is_set_hour & adj_ok);

    bcd_counter #(.MAX(BCD_SEC_MAX), .INIT(8'h00)) u_sec (
        .clk   (CP),
        .rst   (CR),
        .inc   (sec_inc),
        .clear (sec_clr),
        .value (sec_bcd),
        .carry (sec_carry)
    );

    bcd_counter #(.MAX(BCD_MIN_MAX), .INIT(INIT_MIN)) u_min (
        .clk   (CP),
        .rst   (CR),
        .inc   (min_inc),
        .clear (1'b0),
        .value (min_bcd),
        .carry (min_carry)
    );

    bcd_counter #(.MAX(BCD_HOUR_MAX), .INIT(INIT_HOUR)) u_hour (
        .clk   (CP),
        .rst   (CR),
        .inc   (hour_inc),
        .clear (1'b0),
        .value (hour_bcd),
        .carry (hour_carry)
    );

    // Registered so it appears together with 00:00:00.
    always_ff @(posedge CP) begin
        if (CR)
            day_pulse <= 1'b0;
        else
            day_pulse <= is_run & hour_carry;
    end

`ifdef HOURLY_CHIME_EN
    // Evaluated on next-state values so chime moves with sec_bcd.
    logic [7:0] sec_nxt;
    logic [7:0] min_nxt;

    always_comb begin
        sec_nxt = sec_bcd;
        if (sec_clr)
            sec_nxt = 8'h00;
        else if (sec_inc)
            sec_nxt = bcd_step(sec_bcd, BCD_SEC_MAX);
    end

    always_comb begin
        min_nxt = min_bcd;
        if (min_inc)
            min_nxt = bcd_step(min_bcd, BCD_MIN_MAX);
    end

    always_ff @(posedge CP) begin
        if (CR)
            chime <= 1'b0;
        else
            chime <= (state_nxt == ST_RUN) &&
                     (min_nxt == BCD_MIN_MAX) &&
                     (sec_nxt >= CHIME_START);
    end
`endif

endmodule

// File: tb/tb_time_counter.sv
// Directed self-checking bench for time_counter.
// Covers reset, latency, rollover, EN gating, set flow, collisions, chime.
module tb_time_counter;

    logic       CP = 1'b0;
    logic       CR;
    logic       CP_1Hz;
    logic       EN;
    logic       mode_btn;
    logic       adj_btn;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic [1:0] mode;
    logic       day_pulse;
`ifdef HOURLY_CHIME_EN
    logic       chime;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CP = ~CP;

    time_counter #(
        .SYNC_STAGES (2),
        .INIT_HOUR   (8'h23),
        .INIT_MIN    (8'h59)
    ) dut (
        .CP        (CP),
        .CR        (CR),
        .CP_1Hz    (CP_1Hz),
        .EN        (EN),
        .mode_btn  (mode_btn),
        .adj_btn   (adj_btn),
        .hour_bcd  (hour_bcd),
        .min_bcd   (min_bcd),
        .sec_bcd   (sec_bcd),
        .mode      (mode),
        .day_pulse (day_pulse)
`ifdef HOURLY_CHIME_EN
        ,
        .chime     (chime)
`endif
    );

    task automatic check(input string tag,
                         input logic [7:0] obs,
                         input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive a rising/falling pair on the selected inputs.
    task automatic pulse(input logic t, input logic m, input logic a);
        CP_1Hz   = t;
        mode_btn = m;
        adj_btn  = a;
        repeat (4) @(negedge CP);
        CP_1Hz   = 1'b0;
        mode_btn = 1'b0;
        adj_btn  = 1'b0;
        repeat (4) @(negedge CP);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 1'b0);
    endtask

    task automatic adjs(input int n);
        for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        CR       = 1'b1;
        CP_1Hz   = 1'b0;
        EN       = 1'b1;
        mode_btn = 1'b0;
        adj_btn  = 1'b0;
        repeat (2) @(negedge CP);
        CR = 1'b0;

        check("rst_hour", hour_bcd, 8'h23);
        check("rst_min", min_bcd, 8'h59);
        check("rst_sec", sec_bcd, 8'h00);
        check("rst_mode", {6'd0, mode}, 8'h00);
        check("rst_day", {7'd0, day_pulse}, 8'h00);

        ticks(59);
        check("pre_roll_sec", sec_bcd, 8'h59);
        check("pre_roll_min", min_bcd, 8'h59);
        check("pre_roll_hour", hour_bcd, 8'h23);

        // Latency and rollover: change lands on the 3rd sampling edge.
        CP_1Hz = 1'b1;
        @(posedge CP); #1;
        check("lat_e1_sec", sec_bcd, 8'h59);
        @(posedge CP); #1;
        check("lat_e2_sec", sec_bcd, 8'h59);
        @(posedge CP); #1;
        check("lat_e3_sec", sec_bcd, 8'h00);
        check("roll_min", min_bcd, 8'h00);
        check("roll_hour", hour_bcd, 8'h00);
        check("day_hi", {7'd0, day_pulse}, 8'h01);
        @(posedge CP); #1;
        check("day_lo", {7'd0, day_pulse}, 8'h00);
        repeat (46) @(posedge CP);
        #1;
        check("hold_one_inc", sec_bcd, 8'h00);
        @(negedge CP);
        CP_1Hz = 1'b0;
        repeat (6) @(negedge CP);

        EN = 1'b0;
        ticks(5);
        check("en0_sec", sec_bcd, 8'h00);
        check("en0_min", min_bcd, 8'h00);
        EN = 1'b1;
        ticks(1);
        check("en1_sec", sec_bcd, 8'h01);

        // Walk to 10:20:33 via the set modes.
        pulse(1'b0, 1'b1, 1'b0);
        check("to_set_hour", {6'd0, mode}, 8'h01);
        adjs(10);
        check("set_h10", hour_bcd, 8'h10);
        pulse(1'b0, 1'b1, 1'b0);
        adjs(20);
        check("set_m20", min_bcd, 8'h20);
        check("set_sec_frozen", sec_bcd, 8'h01);
        pulse(1'b0, 1'b1, 1'b0);
        check("back_run", {6'd0, mode}, 8'h00);
        check("exit_sec_clr", sec_bcd, 8'h00);
        ticks(33);
        check("t_10_20_33_s", sec_bcd, 8'h33);
        check("t_10_20_33_m", min_bcd, 8'h20);
        check("t_10_20_33_h", hour_bcd, 8'h10);

        pulse(1'b0, 1'b1, 1'b0);
        ticks(3);
        check("sh_tick_ign", sec_bcd, 8'h33);
        adjs(15);
        check("sh_wrap_h01", hour_bcd, 8'h01);
        check("sh_min_keep", min_bcd, 8'h20);
        check("sh_no_day", {7'd0, day_pulse}, 8'h00);

        pulse(1'b0, 1'b1, 1'b0);
        check("to_set_min", {6'd0, mode}, 8'h02);
        adjs(40);
        check("sm_wrap_m00", min_bcd, 8'h00);
        check("sm_hour_keep", hour_bcd, 8'h01);
        pulse(1'b0, 1'b1, 1'b0);
        check("run_again", {6'd0, mode}, 8'h00);
        check("run_sec00", sec_bcd, 8'h00);

        pulse(1'b1, 1'b1, 1'b0);
        check("tick_mode_sec", sec_bcd, 8'h01);
        check("tick_mode_mode", {6'd0, mode}, 8'h01);
        pulse(1'b0, 1'b1, 1'b1);
        check("mode_adj_mode", {6'd0, mode}, 8'h02);
        check("mode_adj_hour", hour_bcd, 8'h01);
        pulse(1'b0, 1'b1, 1'b0);
        check("final_run", {6'd0, mode}, 8'h00);
        check("final_sec", sec_bcd, 8'h00);
        check("final_min", min_bcd, 8'h00);

`ifdef HOURLY_CHIME_EN
        check("chime_idle", {7'd0, chime}, 8'h00);
        pulse(1'b0, 1'b1, 1'b0);
        adjs(11);
        pulse(1'b0, 1'b1, 1'b0);
        adjs(59);
        pulse(1'b0, 1'b1, 1'b0);
        ticks(50);
        check("c_12_59_50_h", hour_bcd, 8'h12);
        check("c_12_59_50_m", min_bcd, 8'h59);
        ticks(4);
        check("chime_54", {7'd0, chime}, 8'h00);
        ticks(1);
        check("chime_55", {7'd0, chime}, 8'h01);
        ticks(4);
        check("chime_59", {7'd0, chime}, 8'h01);
        ticks(1);
        check("chime_00", {7'd0, chime}, 8'h00);
        check("c_13_00_h", hour_bcd, 8'h13);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        adjs(59);
        pulse(1'b0, 1'b1, 1'b0);
        ticks(56);
        check("chime_56", {7'd0, chime}, 8'h01);
        pulse(1'b0, 1'b1, 1'b0);
        check("chime_set_off", {7'd0, chime}, 8'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
